noc_router_buf: RTL and testbench

NOC_ROUTER_BUF -- requirements
Module: noc_router_buf

---
 rtl/noc_router_buf.sv | 173 +++++++++++++++++
 tb/tb_noc_router_buf.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/noc_router_buf.sv
// noc_router_buf: 5-port XY-routing router with per-input FIFOs and one output register per port.
// Define NOC_ROUTER_RR_ARB_EN for round-robin output arbitration; default is fixed priority L>N>E>S>W.
module noc_router_buf #(
    parameter int PACKET_WIDTH = 32,
    parameter int COORD_W      = 4,
    parameter int ROUTER_X     = 0,
    parameter int ROUTER_Y     = 0,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [PACKET_WIDTH-1:0] data_in   [0:4],
    input  logic                    valid_in  [0:4],
    output logic                    ready_out [0:4],
    output logic [PACKET_WIDTH-1:0] data_out  [0:4],
    output logic                    valid_out [0:4],
    input  logic                    ready_in  [0:4]
);
    localparam int NP    = 5;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int HDR_W = 2 * COORD_W;

    localparam logic [2:0] P_N = 3'd0;
    localparam logic [2:0] P_E = 3'd1;
    localparam logic [2:0] P_S = 3'd2;
    localparam logic [2:0] P_W = 3'd3;
    localparam logic [2:0] P_L = 3'd4;

    localparam logic [COORD_W-1:0] RX   = COORD_W'(ROUTER_X);
    localparam logic [COORD_W-1:0] RY   = COORD_W'(ROUTER_Y);
    localparam logic [CNT_W-1:0]   FULL = CNT_W'(FIFO_DEPTH);

    logic [PACKET_WIDTH-1:0] mem_q    [0:4][0:FIFO_DEPTH-1];
    logic [PTR_W-1:0]        wr_ptr_q [0:4];
    logic [PTR_W-1:0]        wr_ptr_d [0:4];
    logic [PTR_W-1:0]        rd_ptr_q [0:4];
    logic [PTR_W-1:0]        rd_ptr_d [0:4];
    logic [CNT_W-1:0]        cnt_q    [0:4];
    logic [CNT_W-1:0]        cnt_d    [0:4];
    logic [PACKET_WIDTH-1:0] dout_q   [0:4];
    logic [PACKET_WIDTH-1:0] dout_d   [0:4];
    logic                    vout_q   [0:4];
    logic                    vout_d   [0:4];

    logic                    push     [0:4];
    logic                    pop      [0:4];
    logic                    can_load [0:4];
    logic [PACKET_WIDTH-1:0] head     [0:4];
    logic [2:0]              route    [0:4];
    logic                    gnt_vld  [0:4];
    logic [2:0]              gnt_idx  [0:4];

`ifdef NOC_ROUTER_RR_ARB_EN
    logic [2:0]              arb_ptr_q [0:4];
`endif

    // Dimension-ordered routing: resolve X fully before Y, then deliver locally.
    function automatic logic [2:0] xy_route(input logic [HDR_W-1:0] hdr);
        logic [COORD_W-1:0] dx;
        logic [COORD_W-1:0] dy;
        dx = hdr[HDR_W-1 -: COORD_W];
        dy = hdr[COORD_W-1:0];
        if (dx > RX)      return P_E;
        else if (dx < RX) return P_W;
        else if (dy > RY) return P_S;
        else if (dy < RY) return P_N;
        else              return P_L;
    endfunction

    always_comb begin
        for (int i = 0; i < NP; i++) begin
            ready_out[i] = (cnt_q[i] != FULL);
            push[i]      = valid_in[i] && (cnt_q[i] != FULL);
            head[i]      = mem_q[i][rd_ptr_q[i]];
            route[i]     = xy_route(head[i][PACKET_WIDTH-1 -: HDR_W]);
            data_out[i]  = dout_q[i];
            valid_out[i] = vout_q[i];
            can_load[i]  = !vout_q[i] || ready_in[i];
        end
    end

    // One arbiter per output; each head requests only its routed output, so it is granted at most once.
    always_comb begin
        int idx;
        idx = 0;
        for (int o = 0; o < NP; o++) begin
            gnt_vld[o] = 1'b0;
            gnt_idx[o] = 3'd0;
            for (int k = 0; k < NP; k++) begin
`ifdef NOC_ROUTER_RR_ARB_EN
                idx = (int'(arb_ptr_q[o]) + 1 + k) % NP;
`else
                idx = (k + NP - 1) % NP;
`endif
                if (!gnt_vld[o] && can_load[o] && (cnt_q[idx] != '0) && (route[idx] == 3'(o))) begin
                    gnt_vld[o] = 1'b1;
                    gnt_idx[o] = 3'(idx);
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NP; i++) begin
            pop[i] = 1'b0;
        end
        for (int o = 0; o < NP; o++) begin
            if (gnt_vld[o]) begin
                pop[gnt_idx[o]] = 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NP; i++) begin
            wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(push[i]);
            rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(pop[i]);
            cnt_d[i]    = cnt_q[i];
            if (push[i] && !pop[i]) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else if (!push[i] && pop[i]) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
        end
        // The output register can drain and reload in the same edge.
        for (int o = 0; o < NP; o++) begin
            vout_d[o] = vout_q[o] && !ready_in[o];
            dout_d[o] = dout_q[o];
            if (gnt_vld[o]) begin
                vout_d[o] = 1'b1;
                dout_d[o] = head[gnt_idx[o]];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NP; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                cnt_q[i]    <= '0;
                vout_q[i]   <= 1'b0;
                dout_q[i]   <= '0;
`ifdef NOC_ROUTER_RR_ARB_EN
                arb_ptr_q[i] <= P_L;
`endif
            end
        end else begin
            for (int i = 0; i < NP; i++) begin
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
                cnt_q[i]    <= cnt_d[i];
                vout_q[i]   <= vout_d[i];
                dout_q[i]   <= dout_d[i];
`ifdef NOC_ROUTER_RR_ARB_EN
                if (gnt_vld[i]) begin
                    arb_ptr_q[i] <= gnt_idx[i];
                end
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NP; i++) begin
            if (push[i]) begin
                mem_q[i][wr_ptr_q[i]] <= data_in[i];
            end
        end
    end

endmodule

// File: tb/tb_noc_router_buf.sv
// Directed bench for noc_router_buf at router (1,1): latency, backpressure, arbitration, wrap, reset, parallel.
module tb_noc_router_buf;
    localparam int PW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [PW-1:0] data_in   [0:4];
    logic          valid_in  [0:4];
    logic          ready_out [0:4];
    logic [PW-1:0] data_out  [0:4];
    logic          valid_out [0:4];
    logic          ready_in  [0:4];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    noc_router_buf #(
        .PACKET_WIDTH(32), .COORD_W(4), .ROUTER_X(1), .ROUTER_Y(1), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .data_in(data_in), .valid_in(valid_in), .ready_out(ready_out),
        .data_out(data_out), .valid_out(valid_out), .ready_in(ready_in)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        for (int i = 0; i < 5; i++) begin
            valid_in[i] = 1'b0;
            data_in[i]  = '0;
        end
    endtask

    function automatic logic [4:0] pack_vo();
        logic [4:0] r;
        for (int i = 0; i < 5; i++) r[i] = valid_out[i];
        return r;
    endfunction

    function automatic logic [4:0] pack_ro();
        logic [4:0] r;
        for (int i = 0; i < 5; i++) r[i] = ready_out[i];
        return r;
    endfunction

    int            n, n2, got, cnt;
    logic          acc, acc2;
    logic [PW-1:0] seen [0:15];
    logic [PW-1:0] exp_w;
    logic [PW-1:0] par_in  [0:4];
    int            par_dst [0:4];

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        for (int i = 0; i < 5; i++) ready_in[i] = 1'b1;
        #12;
        check("rst_valid_out", 64'(pack_vo()), 64'h0);
        check("rst_ready_out", 64'(pack_ro()), 64'h1f);
        check("rst_data_out1", 64'(data_out[1]), 64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single flit LOCAL -> EAST, one-cycle latency
        data_in[4] = 32'h2100ABCD;
        valid_in[4] = 1'b1;
        check("single_ready", 64'(ready_out[4]), 64'h1);
        tick();
        idle_inputs();
        check("single_early", 64'(valid_out[1]), 64'h0);
        tick();
        check("single_valid", 64'(valid_out[1]), 64'h1);
        check("single_data", 64'(data_out[1]), 64'h2100ABCD);
        tick();
        check("single_drained", 64'(valid_out[1]), 64'h0);

        // Backpressure on EAST: output register plus four FIFO entries
        ready_in[1] = 1'b0;
        n = 0;
        for (int c = 0; c < 10; c++) begin
            data_in[4]  = 32'h2100_0000 | n;
            valid_in[4] = 1'b1;
            acc = ready_out[4];
            tick();
            if (acc) n++;
        end
        idle_inputs();
        check("bp_accepted", 64'(n), 64'd5);
        check("bp_ready_low", 64'(ready_out[4]), 64'h0);
        check("bp_valid_held", 64'(valid_out[1]), 64'h1);
        check("bp_data_held", 64'(data_out[1]), 64'h2100_0000);
        tick();
        check("bp_data_stable", 64'(data_out[1]), 64'h2100_0000);
        ready_in[1] = 1'b1;
        got = 0;
        for (int c = 0; c < 20; c++) begin
            if (valid_out[1]) begin
                check($sformatf("bp_order%0d", got), 64'(data_out[1]), 64'(32'h2100_0000 | got));
                got++;
            end
            tick();
        end
        check("bp_count", 64'(got), 64'd5);
        check("bp_ready_back", 64'(ready_out[4]), 64'h1);

        // Contention NORTH vs WEST into LOCAL
        n = 0; n2 = 0; got = 0;
        for (int c = 0; c < 30; c++) begin
            valid_in[0] = (n < 4);
            data_in[0]  = 32'h1100_00A0 + n;
            valid_in[3] = (n2 < 4);
            data_in[3]  = 32'h1100_00B0 + n2;
            acc  = valid_in[0] && ready_out[0];
            acc2 = valid_in[3] && ready_out[3];
            if (valid_out[4] && got < 16) begin
                seen[got] = data_out[4];
                got++;
            end
            tick();
            if (acc) n++;
            if (acc2) n2++;
        end
        idle_inputs();
        check("cont_count", 64'(got), 64'd8);
        for (int k = 0; k < 8; k++) begin
`ifdef NOC_ROUTER_RR_ARB_EN
            exp_w = (k % 2 == 0) ? (32'h1100_00A0 + k / 2) : (32'h1100_00B0 + k / 2);
`else
            exp_w = (k < 4) ? (32'h1100_00A0 + k) : (32'h1100_00B0 + k - 4);
`endif
            check($sformatf("cont_order%0d", k), 64'(seen[k]), 64'(exp_w));
        end

        // Pointer wrap: 12 flits NORTH-in -> EAST with ready_in toggling
        n = 0; got = 0;
        ready_in[1] = 1'b0;
        for (int c = 0; c < 80; c++) begin
            valid_in[0] = (n < 12);
            data_in[0]  = 32'h2100_0000 | n;
            acc = valid_in[0] && ready_out[0];
            if (valid_out[1] && ready_in[1] && got < 16) begin
                seen[got] = data_out[1];
                got++;
            end
            tick();
            if (acc) n++;
            ready_in[1] = !ready_in[1];
        end
        idle_inputs();
        ready_in[1] = 1'b1;
        check("wrap_count", 64'(got), 64'd12);
        for (int k = 0; k < 12; k++) begin
            check($sformatf("wrap_payload%0d", k), 64'(seen[k]), 64'(32'h2100_0000 | k));
        end
        tick();

        // Parallel: five inputs to five distinct outputs in one cycle
        par_in[0] = 32'h2100_0050; par_dst[0] = 1;
        par_in[1] = 32'h0100_0051; par_dst[1] = 3;
        par_in[2] = 32'h1000_0052; par_dst[2] = 0;
        par_in[3] = 32'h1200_0053; par_dst[3] = 2;
        par_in[4] = 32'h1100_0054; par_dst[4] = 4;
        for (int i = 0; i < 5; i++) begin
            data_in[i]  = par_in[i];
            valid_in[i] = 1'b1;
        end
        tick();
        idle_inputs();
        tick();
        check("par_valid", 64'(pack_vo()), 64'h1f);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("par_data_in%0d", i), 64'(data_out[par_dst[i]]), 64'(par_in[i]));
        end
        tick();

        // Reset with three flits buffered toward a stalled EAST
        for (int i = 0; i < 5; i++) ready_in[i] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            data_in[4]  = 32'h2100_00C0 + c;
            valid_in[4] = 1'b1;
            tick();
        end
        idle_inputs();
        check("mid_pre_valid", 64'(valid_out[1]), 64'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(pack_vo()), 64'h0);
        check("mid_rst_ready", 64'(pack_ro()), 64'h1f);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) ready_in[i] = 1'b1;
        // dst (1,0) from router (1,1) routes NORTH under the XY rules
        data_in[4]  = 32'h1000BEEF;
        valid_in[4] = 1'b1;
        tick();
        idle_inputs();
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            for (int o = 0; o < 5; o++) begin
                if (valid_out[o]) begin
                    cnt++;
                    check("mid_after_port", 64'(o), 64'd0);
                    check("mid_after_data", 64'(data_out[o]), 64'h1000BEEF);
                end
            end
        end
        check("mid_after_count", 64'(cnt), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
